program_encoder: RTL and testbench
==================================

Name: program_encoder

Overview:
- Assembler-side counterpart of the core's instruction decoder.
- Accepts decoded instruction descriptors (mnemonic, condition, register fields, immediate) over a valid/ready stream.
- Packs each descriptor into the 32-bit machine word that the decoder interprets, and writes the words sequentially into instruction memory.
- Used by the boot/test loader to fill program memory before the core leaves reset.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, max words written per program (≤ 2^ADDR_W)
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a new program load
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid & in_ready
in_cond  in  4  condition field
in_mnem  in  4  0 ADD, 1 SUB, 2 MUL, 3 MOV, 4 CMP, 5 AND, 6 ORR, 7 PRD, 8 BRD, 9 STP, 10 CME, 11 ADR, 12 LDR, 13 STR, 14 B, 15 illegal
in_s  in  1  set-flags request
in_imm_sel  in  1  1 = immediate operand 2, 0 = register Rm
in_rn / in_rd / in_rm  in  4 each  register fields
in_imm  in  24  imm12 in [11:0] (DP/memory); imm24 (B)
in_last  in  1  marks final descriptor of program
im_we  out  1  instruction-memory write strobe
im_addr  out  ADDR_W  write address
im_wdata  out  32  encoded word
busy  out  1  high in LOAD
done  out  1  level, high in DONE
word_count  out  ADDR_W+1  words written since start
err_illegal  out  1  sticky, illegal mnemonic seen
err_overflow  out  1  sticky, descriptor offered while full

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; address = BASE_ADDR.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -start-> LOAD.
  - LOAD -(accepted in_last) or overflow-> DONE.
  - DONE -start-> LOAD.
  - start in LOAD is ignored.
- On entry to LOAD:
  - address = BASE_ADDR.
  - word_count = 0.
  - err_illegal and err_overflow cleared.
- in_ready = (state == LOAD) & (word_count + pending write < DEPTH).
- Throughput and latency:
  - One descriptor accepted per cycle.
  - The word is registered: im_we=1, im_addr, im_wdata are valid in the cycle after acceptance.
  - The address and word_count increment on that write.
- Word layout: [31:28] cond, [27:26] op, [25:20] funct, [19:16] Rn, [15:12] Rd, [11:0] src2.
- DP mnemonics (0–11):
  - op = 00; funct = {in_imm_sel, cmd, S}.
  - cmd values: ADD 0000, SUB 0001, MUL 0010, MOV 0011, CMP 0100, AND 1000, ORR 1001, PRD 1010, BRD 1011, STP 1100, CME 1101, ADR 1111.
  - src2 = in_imm_sel ? in_imm[11:0] : {8'h00, in_rm}.
  - CMP/CME: S forced to 1 and Rd forced to 0.
  - MOV/ADR: Rn forced to 0.
- LDR/STR:
  - op = 01; funct = 01100L (L=1 for LDR, 0 for STR).
  - src2 = in_imm[11:0].
- B: op = 10; [25:24] = 10; [23:0] = in_imm.
- op = 11 is never emitted.
- Illegal mnemonic (15):
  - Descriptor is consumed; no write occurs; address is unchanged.
  - err_illegal is set.
  - in_last is still honoured.
- Full: when word_count reaches DEPTH, in_ready = 0.
  - in_valid=1 in that state sets err_overflow and moves to DONE on the next edge.
- Accepting in_last together with the DEPTH-th word:
  - The write happens; next state is DONE; no overflow.
- done asserts in the cycle after the final write.
- Async reset mid-LOAD: any pending write is dropped and nothing further is written.

Test Plan:
- ADD R1,R2,#5, cond 1110, imm_sel=1, in_last=1 -> one cycle later im_we=1, im_addr=0, im_wdata=0xE2021005; done=1 the next cycle; word_count=1.
- CMP R3,R4 with in_s=0 and in_rd=7 -> 0xE0930004 (S forced to 1, Rd forced to 0).
- Back-to-back stream, one per cycle: LDR R5,[R6,#8]; STR R5,[R6,#8]; B imm24=0xFFFFFE -> 0xE5965008 @0, 0xE5865008 @1, 0xEAFFFFFE @2; in_ready held at 1; three consecutive im_we cycles.
- Mnemonic 15 between two ADDs -> err_illegal=1; only two writes, to addresses 0 and 1; word_count=2.
- DEPTH=4 with six descriptors offered and no in_last -> four writes; in_ready drops after the 4th acceptance; err_overflow=1; then DONE.
- Reset asserted mid-stream, then start -> no writes during reset; restart writes from BASE_ADDR with word_count=0 and error flags cleared.

Source files
------------

// File: rtl/program_encoder_if.sv
// Descriptor stream from the loader plus the instruction-memory write port.
interface program_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_cond;
   logic [3:0]        in_mnem;
   logic              in_s;
   logic              in_imm_sel;
   logic [3:0]        in_rn;
   logic [3:0]        in_rd;
   logic [3:0]        in_rm;
   logic [23:0]       in_imm;
   logic              in_last;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;

   modport master (
      output in_valid, in_cond, in_mnem, in_s, in_imm_sel,
             in_rn, in_rd, in_rm, in_imm, in_last,
      input  in_ready, im_we, im_addr, im_wdata
   );

   modport slave (
      input  in_valid, in_cond, in_mnem, in_s, in_imm_sel,
             in_rn, in_rd, in_rm, in_imm, in_last,
      output in_ready, im_we, im_addr, im_wdata
   );
endinterface

// File: rtl/program_encoder.sv
// Packs decoded instruction descriptors into 32-bit machine words and
// writes them sequentially into instruction memory.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LOAD   | accepting descriptors, one write per accepted legal descriptor
// DONE   | program complete (last seen or overflow), waiting for start
module program_encoder #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   program_encoder_if.slave  bus,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   word_count,
   output logic              err_illegal,
   output logic              err_overflow
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic              last_q, last_d;
   logic              err_illegal_q, err_illegal_d;
   logic              err_overflow_q, err_overflow_d;
   logic              im_we_q, im_we_d;
   logic [ADDR_W-1:0] im_addr_q, im_addr_d;
   logic [31:0]       im_wdata_q, im_wdata_d;

   logic [ADDR_W:0]   committed;
   logic              full;
   logic              ready;
   logic              accept;
   logic              illegal;

   function automatic logic [31:0] encode(
      input logic [3:0]  cond,
      input logic [3:0]  mnem,
      input logic        s,
      input logic        imm_sel,
      input logic [3:0]  rn,
      input logic [3:0]  rd,
      input logic [3:0]  rm,
      input logic [23:0] imm
   );
      logic [3:0]  cmd;
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rn_f;
      logic [3:0]  rd_f;
      logic [11:0] src2;
      logic        s_f;
      cmd   = 4'h0;
      op    = 2'b00;
      funct = 6'd0;
      rn_f  = rn;
      rd_f  = rd;
      s_f   = s;
      src2  = imm_sel ? imm[11:0] : {8'h00, rm};
      case (mnem)
         4'd0:  cmd = 4'b0000;
         4'd1:  cmd = 4'b0001;
         4'd2:  cmd = 4'b0010;
         4'd3:  cmd = 4'b0011;
         4'd4:  cmd = 4'b0100;
         4'd5:  cmd = 4'b1000;
         4'd6:  cmd = 4'b1001;
         4'd7:  cmd = 4'b1010;
         4'd8:  cmd = 4'b1011;
         4'd9:  cmd = 4'b1100;
         4'd10: cmd = 4'b1101;
         default: cmd = 4'b1111;
      endcase
      // Compares only update flags and have no destination
      if (mnem == 4'd4 || mnem == 4'd10) begin
         s_f  = 1'b1;
         rd_f = 4'h0;
      end
      // Moves and address generation have no first operand
      if (mnem == 4'd3 || mnem == 4'd11) begin
         rn_f = 4'h0;
      end
      funct = {imm_sel, cmd, s_f};
      if (mnem == 4'd12 || mnem == 4'd13) begin
         op    = 2'b01;
         funct = {5'b01100, (mnem == 4'd12)};
         src2  = imm[11:0];
      end
      if (mnem == 4'd14) begin
         return {cond, 2'b10, 2'b10, imm};
      end
      return {cond, op, funct, rn_f, rd_f, src2};
   endfunction

   // A write registered last cycle has not reached word_count yet, so it is
   // counted here to keep the stream from overrunning DEPTH.
   assign committed = word_count_q + {{ADDR_W{1'b0}}, im_we_q};
   assign full      = committed >= DEPTH_C;
   assign ready     = (state_q == S_LOAD) && !last_q && !full;
   assign accept    = bus.in_valid && ready;
   assign illegal   = (bus.in_mnem == 4'd15);

   // Next-state, address/count bookkeeping and registered write port
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      word_count_d   = word_count_q;
      last_d         = last_q;
      err_illegal_d  = err_illegal_q;
      err_overflow_d = err_overflow_q;
      im_we_d        = 1'b0;
      im_addr_d      = im_addr_q;
      im_wdata_d     = im_wdata_q;

      if (im_we_q) begin
         word_count_d = word_count_q + (ADDR_W+1)'(1);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d        = S_LOAD;
               addr_d         = BASE;
               word_count_d   = '0;
               last_d         = 1'b0;
               err_illegal_d  = 1'b0;
               err_overflow_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (illegal) begin
                  err_illegal_d = 1'b1;
               end else begin
                  im_we_d    = 1'b1;
                  im_addr_d  = addr_q;
                  im_wdata_d = encode(bus.in_cond, bus.in_mnem, bus.in_s,
                                      bus.in_imm_sel, bus.in_rn, bus.in_rd,
                                      bus.in_rm, bus.in_imm);
                  addr_d     = addr_q + ADDR_W'(1);
               end
               if (bus.in_last) begin
                  last_d = 1'b1;
               end
            end else if (bus.in_valid && full && !last_q) begin
               err_overflow_d = 1'b1;
               state_d        = S_DONE;
            end
            // Leave LOAD only once the final word has been presented
            if (last_q) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         addr_q         <= BASE;
         word_count_q   <= '0;
         last_q         <= 1'b0;
         err_illegal_q  <= 1'b0;
         err_overflow_q <= 1'b0;
         im_we_q        <= 1'b0;
         im_addr_q      <= '0;
         im_wdata_q     <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         word_count_q   <= word_count_d;
         last_q         <= last_d;
         err_illegal_q  <= err_illegal_d;
         err_overflow_q <= err_overflow_d;
         im_we_q        <= im_we_d;
         im_addr_q      <= im_addr_d;
         im_wdata_q     <= im_wdata_d;
      end
   end

   assign bus.in_ready = ready;
   assign bus.im_we    = im_we_q;
   assign bus.im_addr  = im_addr_q;
   assign bus.im_wdata = im_wdata_q;
   assign busy         = (state_q == S_LOAD);
   assign done         = (state_q == S_DONE);
   assign word_count   = word_count_q;
   assign err_illegal  = err_illegal_q;
   assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_program_encoder.sv
// Bench for program_encoder: literal vector table, hand-written corner
// sequences and random programs against a behavioural encoder model.
module tb_program_encoder;
   localparam int AW = 8;

   typedef struct {
      logic [3:0]  mnem;
      logic [3:0]  cond;
      logic        s;
      logic        imm_sel;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [3:0]  rm;
      logic [23:0] imm;
   } desc_t;

   typedef struct {
      desc_t       d;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start4 = 1'b0;
   always #5 clk = ~clk;

   program_encoder_if #(.ADDR_W(AW)) bus ();
   program_encoder_if #(.ADDR_W(AW)) bus4 ();

   logic          busy, done, err_illegal, err_overflow;
   logic [AW:0]   word_count;
   logic          busy4, done4, err_illegal4, err_overflow4;
   logic [AW:0]   word_count4;

   program_encoder #(.ADDR_W(AW), .DEPTH(256), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave),
      .busy(busy), .done(done), .word_count(word_count),
      .err_illegal(err_illegal), .err_overflow(err_overflow)
   );

   program_encoder #(.ADDR_W(AW), .DEPTH(4), .BASE_ADDR(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .bus(bus4.slave),
      .busy(busy4), .done(done4), .word_count(word_count4),
      .err_illegal(err_illegal4), .err_overflow(err_overflow4)
   );

   // The small instance sees the same descriptor fields; only valid differs
   assign bus4.in_cond    = bus.in_cond;
   assign bus4.in_mnem    = bus.in_mnem;
   assign bus4.in_s       = bus.in_s;
   assign bus4.in_imm_sel = bus.in_imm_sel;
   assign bus4.in_rn      = bus.in_rn;
   assign bus4.in_rd      = bus.in_rd;
   assign bus4.in_rm      = bus.in_rm;
   assign bus4.in_imm     = bus.in_imm;
   assign bus4.in_last    = bus.in_last;

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    stalls = 0;
   wr_t   wq[$];
   wr_t   wq4[$];
   desc_t prog[$];
   vec_t  vecs[12];

   // Write monitor, sampled on the falling edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.im_we === 1'b1) wq.push_back('{int'(bus.im_addr), bus.im_wdata, cyc});
      if (bus4.im_we === 1'b1) wq4.push_back('{int'(bus4.im_addr), bus4.im_wdata, cyc});
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic desc_t mk(input int mnem, input int cond, input int s, input int sel,
                                input int rn, input int rd, input int rm, input int imm);
      desc_t d;
      d.mnem = 4'(mnem); d.cond = 4'(cond); d.s = 1'(s); d.imm_sel = 1'(sel);
      d.rn = 4'(rn); d.rd = 4'(rd); d.rm = 4'(rm); d.imm = 24'(imm);
      return d;
   endfunction

   // Reference encoder built from the field layout with plain arithmetic
   function automatic logic [31:0] ref_encode(input desc_t d);
      int unsigned cmd_tab[12] = '{0, 1, 2, 3, 4, 8, 9, 10, 11, 12, 13, 15};
      int unsigned c, m, rn, rd, s, funct, src2, w;
      c  = d.cond; m = d.mnem; rn = d.rn; rd = d.rd; s = d.s;
      if (m == 14) begin
         w = c * 268435456 + 2 * 67108864 + 2 * 16777216 + int'(d.imm);
      end else if (m == 12 || m == 13) begin
         funct = (m == 12) ? 25 : 24;
         w = c * 268435456 + 67108864 + funct * 1048576 + rn * 65536 + rd * 4096
             + (int'(d.imm) % 4096);
      end else begin
         if (m == 4 || m == 10) begin s = 1; rd = 0; end
         if (m == 3 || m == 11) rn = 0;
         src2  = d.imm_sel ? (int'(d.imm) % 4096) : int'(d.rm);
         funct = int'(d.imm_sel) * 32 + cmd_tab[m] * 2 + s;
         w = c * 268435456 + funct * 1048576 + rn * 65536 + rd * 4096 + src2;
      end
      return w;
   endfunction

   task automatic set_bus(input desc_t d, input bit last);
      bus.in_mnem = d.mnem; bus.in_cond = d.cond; bus.in_s = d.s;
      bus.in_imm_sel = d.imm_sel; bus.in_rn = d.rn; bus.in_rd = d.rd;
      bus.in_rm = d.rm; bus.in_imm = d.imm; bus.in_last = last;
   endtask

   task automatic pulse_start();
      bus.in_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one descriptor (called on a falling edge, returns on one)
   task automatic send(input desc_t d, input bit last, input int gap);
      int n;
      repeat (gap) begin bus.in_valid = 1'b0; @(negedge clk); end
      set_bus(d, last);
      bus.in_valid = 1'b1;
      #1;
      n = 0;
      while (bus.in_ready !== 1'b1) begin
         n++;
         stalls++;
         if (n > 50) begin
            chk("ready_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk); #1;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      chk("done_reached", 64'(done), 64'd1);
   endtask

   // Run prog[] as one program and compare against the model
   task automatic run_prog(input int gapmax);
      logic [31:0] exp_w[$];
      bit          exp_ill = 0;
      wq.delete();
      pulse_start();
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("wc_after_start", 64'(word_count), 64'd0);
      foreach (prog[i]) begin
         if (prog[i].mnem == 4'd15) exp_ill = 1;
         else exp_w.push_back(ref_encode(prog[i]));
         send(prog[i], (i == prog.size() - 1), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      end
      wait_done(10);
      chk("nwrites", 64'(wq.size()), 64'(exp_w.size()));
      foreach (exp_w[k]) begin
         if (k < wq.size()) begin
            chk("waddr", 64'(wq[k].addr), 64'(k));
            chk("wdata", 64'(wq[k].data), 64'(exp_w[k]));
         end
      end
      chk("word_count", 64'(word_count), 64'(exp_w.size()));
      chk("err_illegal", 64'(err_illegal), 64'(exp_ill));
      chk("err_overflow", 64'(err_overflow), 64'd0);
   endtask

   // Hold valid on the DEPTH=4 instance until it finishes
   task automatic run_small(input int last_at, output int accepts);
      int n = 0;
      accepts = 0;
      wq4.delete();
      bus4.in_valid = 1'b0;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      set_bus(mk(0, 14, 0, 1, 2, 1, 0, 5), 1'b0);
      while (done4 !== 1'b1 && n < 20) begin
         bus.in_last = (accepts == last_at);
         bus4.in_valid = (n < 6);
         #1;
         if (bus4.in_valid && bus4.in_ready) accepts++;
         @(negedge clk);
         n++;
      end
      bus4.in_valid = 1'b0;
      bus.in_last = 1'b0;
      chk("small_done", 64'(done4), 64'd1);
   endtask

   initial begin
      int acc, pre;
      vecs[0]  = '{mk(0, 14, 0, 1, 2, 1, 0, 5),            32'hE2021005};
      vecs[1]  = '{mk(4, 14, 0, 0, 3, 7, 4, 0),            32'hE0930004};
      vecs[2]  = '{mk(12, 14, 0, 0, 6, 5, 0, 8),           32'hE5965008};
      vecs[3]  = '{mk(13, 14, 0, 0, 6, 5, 0, 8),           32'hE5865008};
      vecs[4]  = '{mk(14, 14, 0, 0, 0, 0, 0, 24'hFFFFFE),  32'hEAFFFFFE};
      vecs[5]  = '{mk(3, 0, 0, 0, 5, 1, 9, 0),             32'h00601009};
      vecs[6]  = '{mk(10, 1, 0, 1, 2, 3, 0, 24'h000ABC),   32'h13B20ABC};
      vecs[7]  = '{mk(11, 2, 1, 1, 5, 4, 0, 24'hFFF123),   32'h23F04123};
      vecs[8]  = '{mk(6, 10, 1, 0, 7, 8, 15, 24'hFFFFFF),  32'hA137800F};
      vecs[9]  = '{mk(1, 3, 1, 1, 9, 10, 0, 24'h000FFF),   32'h3239AFFF};
      vecs[10] = '{mk(7, 5, 0, 0, 1, 2, 3, 0),             32'h51412003};
      vecs[11] = '{mk(9, 15, 0, 1, 0, 0, 0, 24'h000001),   32'hF3800001};

      bus.in_valid = 1'b0; bus4.in_valid = 1'b0;
      set_bus(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

      // Reset state
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wc", 64'(word_count), 64'd0);
      chk("rst_errs", 64'({err_illegal, err_overflow}), 64'd0);
      chk("rst_we", 64'(bus.im_we), 64'd0);
      chk("rst_addr_data", 64'({bus.im_addr, bus.im_wdata}), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single ADD with last: write latency and done timing
      wq.delete();
      pulse_start();
      set_bus(vecs[0].d, 1'b1);
      bus.in_valid = 1'b1;
      #1 chk("add_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      chk("add_we", 64'(bus.im_we), 64'd1);
      chk("add_addr", 64'(bus.im_addr), 64'd0);
      chk("add_data", 64'(bus.im_wdata), 64'hE2021005);
      chk("add_done_early", 64'(done), 64'd0);
      @(negedge clk);
      chk("add_done", 64'(done), 64'd1);
      chk("add_wc", 64'(word_count), 64'd1);
      chk("add_we_off", 64'(bus.im_we), 64'd0);

      // Table of literal vectors as one back-to-back program
      prog.delete();
      foreach (vecs[i]) prog.push_back(vecs[i].d);
      run_prog(0);
      foreach (vecs[i]) if (i < wq.size()) chk("vec_word", 64'(wq[i].data), 64'(vecs[i].exp));

      // LDR/STR/B back-to-back without stalls
      prog.delete();
      prog.push_back(vecs[2].d); prog.push_back(vecs[3].d); prog.push_back(vecs[4].d);
      stalls = 0;
      run_prog(0);
      chk("b2b_stalls", 64'(stalls), 64'd0);
      if (wq.size() == 3) chk("b2b_consecutive", 64'(wq[2].cyc - wq[0].cyc), 64'd2);
      else chk("b2b_count", 64'(wq.size()), 64'd3);

      // Illegal mnemonic between two ADDs
      prog.delete();
      prog.push_back(vecs[0].d);
      prog.push_back(mk(15, 14, 0, 0, 1, 2, 3, 0));
      prog.push_back(mk(0, 14, 1, 0, 4, 5, 6, 0));
      run_prog(0);

      // Restart clears the sticky error
      prog.delete();
      prog.push_back(vecs[5].d);
      run_prog(1);

      // Illegal descriptor carrying last still ends the program
      prog.delete();
      prog.push_back(vecs[1].d);
      prog.push_back(mk(15, 0, 0, 0, 0, 0, 0, 0));
      run_prog(0);

      // DEPTH=4: six offered, no last -> overflow
      run_small(99, acc);
      chk("ovf_accepts", 64'(acc), 64'd4);
      chk("ovf_writes", 64'(wq4.size()), 64'd4);
      foreach (wq4[i]) chk("ovf_addr", 64'(wq4[i].addr), 64'(i));
      chk("ovf_flag", 64'(err_overflow4), 64'd1);
      chk("ovf_wc", 64'(word_count4), 64'd4);

      // DEPTH=4: last on the 4th word -> no overflow
      run_small(3, acc);
      chk("full_last_accepts", 64'(acc), 64'd4);
      chk("full_last_writes", 64'(wq4.size()), 64'd4);
      chk("full_last_ovf", 64'(err_overflow4), 64'd0);
      chk("full_last_wc", 64'(word_count4), 64'd4);

      // Reset mid-stream drops the in-flight write
      prog.delete();
      pulse_start();
      set_bus(vecs[0].d, 1'b0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      pre = wq.size();
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_we", 64'(bus.im_we), 64'd0);
         chk("rst_mid_busy", 64'(busy), 64'd0);
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("idle_no_write", 64'(bus.im_we), 64'd0);
      end
      bus.in_valid = 1'b0;
      chk("rst_mid_nowrites", 64'(wq.size()), 64'(pre));
      prog.push_back(vecs[6].d); prog.push_back(vecs[7].d);
      run_prog(0);

      // Random programs against the model
      for (int p = 0; p < 15; p++) begin
         int len = int'($urandom_range(1, 12));
         prog.delete();
         for (int i = 0; i < len; i++) begin
            prog.push_back(mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                              int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                              int'($urandom_range(0, 15)), int'($urandom & 32'hFFFFFF)));
         end
         run_prog(2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
